// File: rtl/inst_mem_pkg.sv
// Shared types, constants and the parity helper for the instruction memory.
// Parity storage/checking is only built with IMEM_PARITY_EN defined.
package inst_mem_pkg;

    localparam int unsigned MAX_DATA_W = 64;

    // Instruction returned for out-of-range fetches and written by the clear sweep.
    localparam logic [MAX_DATA_W-1:0] NOP_WORD = '0;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    // Which source drives fetch_data; held between fetches.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_BYP,
        SRC_NOP
    } src_e;

    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Synchronous-write, synchronous-read storage array; no reset on the contents.
// Word width is set by the parent (data only, or data plus parity bit).
module inst_mem_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: clear sweep, program-load port, 1-cycle fetch.
// Define IMEM_PARITY_EN to store a parity bit per word and add fetch_par_err.
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
`ifdef IMEM_PARITY_EN
    ,
    output logic              fetch_par_err
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [AW-1:0]     LAST      = AW'(DEPTH - 1);
    localparam logic [DATA_W-1:0] NOP       = NOP_WORD[DATA_W-1:0];

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              valid_q, fault_q, lerr_q;
    src_e              src_q;
    logic [DATA_W-1:0] byp_q;

    logic              ready, fetch_ok, load_ok, bypass, fetch_go;
    logic              mem_we, mem_re;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] wr_word;
    logic [MEM_W-1:0]  mem_wdata, mem_rdata;

    assign ready    = (state_q == ST_READY);
    // Full-width unsigned compare so high addresses never alias into the array.
    assign fetch_ok = ({1'b0, fetch_addr} < DEPTH_EXT);
    assign load_ok  = ({1'b0, load_addr} < DEPTH_EXT);
    assign fetch_go = ready && fetch_req;
    assign bypass   = fetch_go && fetch_ok && load_we && load_ok && (load_addr == fetch_addr);
    assign mem_re   = fetch_go && fetch_ok && !bypass;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        wr_word   = NOP;
        if (!ready) begin
            mem_we = 1'b1;
        end else if (load_we && load_ok) begin
            mem_we    = 1'b1;
            mem_waddr = load_addr[AW-1:0];
            wr_word   = load_data;
        end
    end

`ifdef IMEM_PARITY_EN
    assign mem_wdata = {even_parity(MAX_DATA_W'(wr_word)), wr_word};
`else
    assign mem_wdata = wr_word;
`endif

    inst_mem_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (fetch_addr[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result source and fault only move on an accepted fetch, so they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            lerr_q  <= 1'b0;
            src_q   <= SRC_ZERO;
            byp_q   <= '0;
        end else begin
            valid_q <= fetch_go;
            lerr_q  <= load_we && (!ready || !load_ok);
            if (fetch_go) begin
                fault_q <= !fetch_ok;
                if (!fetch_ok) begin
                    src_q <= SRC_NOP;
                end else if (bypass) begin
                    src_q <= SRC_BYP;
                end else begin
                    src_q <= SRC_RAM;
                end
                if (bypass) begin
                    byp_q <= load_data;
                end
            end
        end
    end

    always_comb begin
        fetch_data = '0;
        unique case (src_q)
            SRC_ZERO: fetch_data = '0;
            SRC_RAM:  fetch_data = mem_rdata[DATA_W-1:0];
            SRC_BYP:  fetch_data = byp_q;
            SRC_NOP:  fetch_data = NOP;
            default:  fetch_data = '0;
        endcase
    end

    assign init_done   = ready;
    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign load_err    = lerr_q;

`ifdef IMEM_PARITY_EN
    // Bypassed words never touched the array, so only RAM reads are checked.
    assign fetch_par_err = valid_q && (src_q == SRC_RAM) &&
        (even_parity(MAX_DATA_W'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W]);
`endif

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Randomized scoreboard bench for inst_mem_ctrl (DEPTH=8) with a behavioural memory model.
module tb_inst_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done, fetch_req, fetch_valid, fetch_fault, load_we, load_err;
    logic [AW-1:0] fetch_addr, load_addr;
    logic [DW-1:0] fetch_data, load_data;
`ifdef IMEM_PARITY_EN
    logic          fetch_par_err;
`endif

    inst_mem_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_fault (fetch_fault),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_err    (load_err)
`ifdef IMEM_PARITY_EN
        ,
        .fetch_par_err (fetch_par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          fault;
        logic          lerr;
        logic          idone;
        logic          perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [DW-1:0] mmem [DP];
    bit            pbad [DP];
    int            edges;
    logic [DW-1:0] last_d;
    logic          last_f;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t it;
        #1;
        if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            chk("fetch_valid", 32'(fetch_valid), 32'(it.valid));
            chk("fetch_data", fetch_data, it.data);
            chk("fetch_fault", 32'(fetch_fault), 32'(it.fault));
            chk("load_err", 32'(load_err), 32'(it.lerr));
            chk("init_done", 32'(init_done), 32'(it.idone));
`ifdef IMEM_PARITY_EN
            chk("fetch_par_err", 32'(fetch_par_err), 32'(it.perr));
`endif
        end
    end

    // Called at a negedge; returns at the negedge that releases reset.
    task automatic do_reset();
        rst       = 1'b1;
        fetch_req = 1'b0;
        load_we   = 1'b0;
        #1;
        chk("rst init_done", 32'(init_done), 32'd0);
        chk("rst fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst fetch_data", fetch_data, 32'd0);
        chk("rst fetch_fault", 32'(fetch_fault), 32'd0);
        chk("rst load_err", 32'(load_err), 32'd0);
`ifdef IMEM_PARITY_EN
        chk("rst fetch_par_err", 32'(fetch_par_err), 32'd0);
`endif
        for (int i = 0; i < DP; i++) begin
            mmem[i] = '0;
            pbad[i] = 1'b0;
        end
        edges  = 0;
        last_d = '0;
        last_f = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one cycle at the current negedge, predicts its result, then waits a cycle.
    task automatic cyc(input logic req, input logic [AW-1:0] a, input logic we,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld);
        exp_t it;
        fetch_req  = req;
        fetch_addr = a;
        load_we    = we;
        load_addr  = la;
        load_data  = ld;
        it.valid = 1'b0;
        it.perr  = 1'b0;
        if (edges >= DP) begin
            it.valid = req;
            if (req) begin
                if (int'(a) < DP) begin
                    if (we && la == a) begin
                        last_d = ld;
                    end else begin
                        last_d  = mmem[a];
                        it.perr = pbad[a];
                    end
                    last_f = 1'b0;
                end else begin
                    last_d = '0;
                    last_f = 1'b1;
                end
            end
            it.lerr = we && (int'(la) >= DP);
            if (we && int'(la) < DP) begin
                mmem[la] = ld;
                pbad[la] = 1'b0;
            end
        end else begin
            it.lerr = we;
        end
        it.data  = last_d;
        it.fault = last_f;
        edges++;
        it.idone = (edges >= DP);
        exp_q.push_back(it);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r < 12) return AW'($urandom_range(0, DP + 1));
        if (r < 14) return AW'(32'($urandom_range(0, 3)) * 256 + 32'($urandom_range(0, 9)));
        return AW'($urandom);
    endfunction

    initial begin
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        do_reset();

        // Sweep window: fetches ignored, loads dropped with load_err
        for (int i = 0; i < DP; i++)
            cyc(1'($urandom), rand_addr(), 1'($urandom), rand_addr(), $urandom);

        cyc(1'b1, 16'd3, 1'b0, '0, '0);
        cyc(1'b0, '0, 1'b1, 16'd0, 32'h0000_0800);
        cyc(1'b1, 16'd0, 1'b0, '0, '0);
        cyc(1'b1, 16'd2, 1'b1, 16'd2, 32'h0020_1000);
        cyc(1'b1, 16'd8, 1'b0, '0, '0);
        cyc(1'b0, '0, 1'b1, 16'd8, 32'hDEAD_BEEF);
        cyc(1'b1, 16'd0, 1'b0, '0, '0);
        cyc(1'b1, 16'd2, 1'b1, 16'd5, 32'h1111_2222);
        cyc(1'b1, 16'hFFFF, 1'b0, '0, '0);
        idle(2);

`ifdef IMEM_PARITY_EN
        cyc(1'b0, '0, 1'b1, 16'd1, 32'h1234_5677);
        dut.u_array.mem[1][DW] = ~dut.u_array.mem[1][DW];
        pbad[1] = 1'b1;
        cyc(1'b1, 16'd1, 1'b0, '0, '0);
        cyc(1'b1, 16'd2, 1'b0, '0, '0);
        cyc(1'b1, 16'd1, 1'b0, '0, '0);
        idle(1);
`endif

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 2) == 0),
                rand_addr(), $urandom);
        idle(1);

        // Reset mid-sweep, then reset in READY right after a fetch result
        do_reset();
        idle(4);
        do_reset();
        idle(DP + 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, AW'(i), 32'hA5A5_0000 + 32'(i));
        cyc(1'b1, 16'd1, 1'b0, '0, '0);
        do_reset();
        idle(DP);
        for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i), 1'b0, '0, '0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Parametrised instruction memory with a run-time program-load port, a post-reset clear sweep and a one-cycle registered fetch port with valid/fault flags. It replaces the fixed, self-initialising instruction store in front of the core's fetch stage. Software, a testbench or a boot loader writes programs through the load port, and the core fetches through a request/valid handshake. Out-of-range fetches return a NOP word and are flagged instead of returning undefined data.

## Interface
Parameters:
- DATA_W, default 32: instruction word width.
- ADDR_W, default 16: fetch and load address width.
- DEPTH, default 256: number of words implemented. Must be no greater than 2**ADDR_W.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- init_done, output, 1: high once the clear sweep is complete.
- fetch_req, input, 1: fetch request.
- fetch_addr, input, ADDR_W: word address of the fetch.
- fetch_valid, output, 1: fetch_data and fetch_fault are valid this cycle.
- fetch_data, output, DATA_W: fetched word.
- fetch_fault, output, 1: the fetch address was at or above DEPTH.
- load_we, input, 1: program write strobe.
- load_addr, input, ADDR_W: program write address.
- load_data, input, DATA_W: program write data.
- load_err, output, 1: one-cycle pulse when a write is dropped (out of range, or issued during INIT).
- fetch_par_err, output, 1: present only with IMEM_PARITY_EN.

## Operation
- FSM states: INIT and READY.
- Reset asserted:
  - state becomes INIT and the sweep counter clears to 0.
  - All outputs go to 0 (init_done, fetch_valid, fetch_data, fetch_fault, load_err, fetch_par_err).
- INIT state:
  - Writes NOP_WORD to address cnt, then increments cnt; one word per cycle.
  - After writing DEPTH-1, moves to READY and sets init_done=1.
  - fetch_req is ignored and fetch_valid stays 0.
  - load_we is dropped and pulses load_err.
- READY state:
  - Fetch: a cycle with fetch_req=1 gives fetch_valid=1 on the next cycle.
    - If fetch_addr < DEPTH: fetch_data = mem[fetch_addr] and fetch_fault=0.
    - Otherwise: fetch_data = NOP_WORD and fetch_fault=1.
  - A cycle with fetch_req=0 gives fetch_valid=0 on the next cycle. fetch_data and fetch_fault hold their last values.
  - Load: with load_we=1 and load_addr < DEPTH, the word is written at the clock edge.
  - Load with load_addr >= DEPTH: the write is dropped and load_err=1 on the next cycle.
- Fetch and load to the same address in the same cycle: the fetch returns load_data (write-first bypass).
- Fetch and load to different addresses proceed concurrently with no stall.
- READY is only left through reset.
- Reset asserted mid-sweep or mid-fetch: everything returns to INIT and the full clear sweep re-runs. Memory contents are not preserved.

## Timing
- Clear sweep: init_done rises exactly DEPTH cycles after the first rising edge following rst deassertion.
- Fetch latency is 1 cycle. Back-to-back requests give one result per cycle.
- A load at edge N is visible to a fetch issued in cycle N (via the bypass) and in every later cycle.
- load_err is a single-cycle pulse, one cycle after the offending load_we.
- Address comparisons are unsigned over the full ADDR_W bits. No wrap-around: addresses at or above DEPTH are never aliased.

## Configuration
- Macro IMEM_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits; the extra bit is the even parity of the data, computed on every write (both sweep and load).
  - On each valid in-range fetch, parity is rechecked and fetch_par_err equals the mismatch, in the same cycle as fetch_valid.
  - The data is still returned unmodified.
  - Out-of-range fetches give fetch_par_err=0.
- Not defined: the array is DATA_W bits wide and the fetch_par_err port does not exist.

## Structure
- Package inst_mem_pkg holds:
  - NOP_WORD, default all-zero DATA_W bits.
  - The FSM state enum {ST_INIT, ST_READY}.
  - The parity function.
- Sub-module inst_mem_array: a single-port-write / single-port-read synchronous RAM of DEPTH entries, with optional parity bit, and no reset on the storage.
- inst_mem_ctrl owns the FSM, sweep counter, range checks, bypass and output registers.

## Test plan
- Release reset with DEPTH=8 -> init_done=0 for 8 cycles, then 1. A fetch of address 3 returns 32'h0 with fault=0.
- Load 0x0000_0800 at address 0, then fetch address 0 the next cycle -> fetch_valid=1, data=0x0000_0800 one cycle later.
- Same-cycle load of 0x0020_1000 and fetch, both at address 2 -> data=0x0020_1000.
- Fetch address 8 with DEPTH=8 -> data=NOP_WORD and fault=1. A load to address 8 -> load_err pulses and memory is unchanged.
- Assert rst mid-sweep (cycle 4) and during a READY fetch -> all outputs 0, sweep restarts, and previously loaded words read back as 0.
- With IMEM_PARITY_EN, force-flip the stored parity bit of address 1 and fetch it -> fetch_par_err=1. Clean addresses give 0.
